// File: rtl/remote_comm.sv
// Host-side UART command source: sends a 16-bit command as two 8N1 bytes (high byte first)
// and independently receives single-byte responses.
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  localparam logic [11:0] BAUD_LAST = 12'(BAUD_DIV - 1);
  localparam logic [11:0] BAUD_HALF = 12'(BAUD_DIV / 2);

  typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;

  tx_state_t   tx_state, tx_next;
  logic [15:0] cmd_lat;
  logic [9:0]  tx_shift;
  logic [3:0]  tx_bits;
  logic [11:0] tx_baud;
  logic        tx_tick, tx_frame_done, load_high, load_low, set_snt;

  assign tx_tick       = (tx_baud == 12'd0);
  assign tx_frame_done = (tx_state != TX_IDLE) && tx_tick && (tx_bits == 4'd9);
  // Shift register idles at all ones, so its LSB is a glitch-free line driver.
  assign TX            = tx_shift[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next   = tx_state;
    load_high = 1'b0;
    load_low  = 1'b0;
    set_snt   = 1'b0;
    case (tx_state)
      TX_IDLE: if (snd_cmd) begin
        load_high = 1'b1;
        tx_next   = TX_HIGH;
      end
      TX_HIGH: if (tx_frame_done) begin
        load_low = 1'b1;
        tx_next  = TX_LOW;
      end
      TX_LOW: if (tx_frame_done) begin
        set_snt = 1'b1;
        tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '1;
      tx_bits  <= 4'd0;
      tx_baud  <= 12'd0;
      cmd_lat  <= 16'd0;
      cmd_snt  <= 1'b0;
    end else begin
      if (load_high) begin
        cmd_lat  <= cmd;
        cmd_snt  <= 1'b0;
        tx_shift <= {1'b1, cmd[15:8], 1'b0};
        tx_bits  <= 4'd0;
        tx_baud  <= BAUD_LAST;
      end else if (load_low) begin
        // Low frame starts on the same edge the high stop bit ends: no idle gap.
        tx_shift <= {1'b1, cmd_lat[7:0], 1'b0};
        tx_bits  <= 4'd0;
        tx_baud  <= BAUD_LAST;
      end else if (tx_state != TX_IDLE) begin
        if (tx_tick) begin
          tx_shift <= {1'b1, tx_shift[9:1]};
          tx_bits  <= tx_bits + 4'd1;
          tx_baud  <= BAUD_LAST;
        end else begin
          tx_baud  <= tx_baud - 12'd1;
        end
      end
      if (set_snt) cmd_snt <= 1'b1;
    end
  end

  rx_state_t   rx_state, rx_next;
  logic        rx_meta, rx_sync, rx_prev;
  logic [7:0]  rx_shift;
  logic [3:0]  rx_bits;
  logic [11:0] rx_baud;
  logic        rx_fall, rx_tick, rx_start, rx_frame_done;

  assign rx_fall       = rx_prev & ~rx_sync;
  assign rx_tick       = (rx_baud == 12'd0);
  assign rx_frame_done = (rx_state == RX_RECV) && rx_tick && (rx_bits == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next  = rx_state;
    rx_start = 1'b0;
    case (rx_state)
      RX_IDLE: if (rx_fall) begin
        rx_start = 1'b1;
        rx_next  = RX_RECV;
      end
      RX_RECV: if (rx_frame_done) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_shift <= 8'd0;
      rx_bits  <= 4'd0;
      rx_baud  <= 12'd0;
      resp     <= 8'd0;
      resp_rdy <= 1'b0;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (rx_start) begin
        // Half-bit preload puts every later sample near mid-bit.
        resp_rdy <= 1'b0;
        rx_bits  <= 4'd0;
        rx_baud  <= BAUD_HALF;
      end else if (rx_state == RX_RECV) begin
        if (rx_tick) begin
          // Sample 0 is the start bit and sample 9 the stop bit; neither is checked.
          if (rx_bits != 4'd0 && rx_bits != 4'd9) rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_bits <= rx_bits + 4'd1;
          rx_baud <= BAUD_LAST;
          if (rx_bits == 4'd9) begin
            resp     <= rx_shift;
            resp_rdy <= 1'b1;
          end
        end else begin
          rx_baud <= rx_baud - 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm: command framing/timing, response reception, concurrency, reset abort.
module tb_remote_comm;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  int n_tests = 0;
  int n_fail  = 0;

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .snd_cmd(snd_cmd),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue a command and sample every TX bit at its midpoint; optionally disturb cmd and
  // re-strobe snd_cmd mid-frame, neither of which may affect the transmitted bytes.
  task automatic run_cmd(input logic [15:0] c, input bit perturb);
    logic [19:0] got;
    logic [19:0] exp;
    exp = {1'b1, c[7:0], 1'b0, 1'b1, c[15:8], 1'b0};
    got = '0;
    cmd = c;
    snd_cmd = 1'b1;
    step();
    snd_cmd = 1'b0;
    chk("tx_start_fall", {31'd0, TX}, 32'd0);
    for (int t = 1; t <= 20 * BD + 2; t++) begin
      step();
      if (t == 1) begin
        chk("snt_clear", {31'd0, cmd_snt}, 32'd0);
        if (perturb) cmd = 16'hFFFF;
      end
      if (perturb && t == 5 * BD) snd_cmd = 1'b1;
      if (perturb && t == 5 * BD + 1) snd_cmd = 1'b0;
      if ((t % BD) == BD / 2 && (t / BD) < 20) got[t / BD] = TX;
      if (t == 20 * BD - 3) chk("snt_early", {31'd0, cmd_snt}, 32'd0);
    end
    chk("snt_done", {31'd0, cmd_snt}, 32'd1);
    chk("tx_high_frame", {22'd0, got[9:0]}, {22'd0, exp[9:0]});
    chk("tx_low_frame", {22'd0, got[19:10]}, {22'd0, exp[19:10]});
    chk("tx_idle_after", {31'd0, TX}, 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = frame[i];
      repeat (BD) step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    RX = 1'b1;
    snd_cmd = 1'b0;
    cmd = 16'h0000;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("reset_tx", {31'd0, TX}, 32'd1);
    chk("reset_cmd_snt", {31'd0, cmd_snt}, 32'd0);
    chk("reset_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    chk("reset_resp", {24'd0, resp}, 32'h00);
  endtask

  task automatic test_cmd_basic();
    run_cmd(16'h2000, 1'b0);
    repeat (BD) step();
  endtask

  task automatic test_cmd_latch();
    run_cmd(16'h7020, 1'b1);
    repeat (BD) step();
  endtask

  task automatic test_rx();
    fork
      send_rx(8'hA5);
      begin
        repeat (9 * BD) step();
        chk("rx_not_yet", {31'd0, resp_rdy}, 32'd0);
      end
    join
    chk("rx_rdy", {31'd0, resp_rdy}, 32'd1);
    chk("rx_data", {24'd0, resp}, 32'hA5);
    repeat (3 * BD) step();
    chk("rx_rdy_held", {31'd0, resp_rdy}, 32'd1);
  endtask

  task automatic test_back_to_back();
    fork
      begin
        send_rx(8'h5A);
        send_rx(8'h5A);
      end
      begin
        repeat (BD) step();
        chk("b2b_drop1", {31'd0, resp_rdy}, 32'd0);
        repeat (9 * BD) step();
        chk("b2b_rdy1", {31'd0, resp_rdy}, 32'd1);
        chk("b2b_data1", {24'd0, resp}, 32'h5A);
        repeat (BD) step();
        chk("b2b_drop2", {31'd0, resp_rdy}, 32'd0);
        repeat (9 * BD) step();
        chk("b2b_rdy2", {31'd0, resp_rdy}, 32'd1);
        chk("b2b_data2", {24'd0, resp}, 32'h5A);
      end
    join
    repeat (BD) step();
  endtask

  task automatic test_simultaneous();
    fork
      run_cmd(16'h4001, 1'b0);
      begin
        repeat (2) step();
        send_rx(8'hA5);
      end
    join
    chk("sim_rx_rdy", {31'd0, resp_rdy}, 32'd1);
    chk("sim_rx_data", {24'd0, resp}, 32'hA5);
    repeat (BD) step();
  endtask

  task automatic test_reset_midframe();
    cmd = 16'h00FF;
    snd_cmd = 1'b1;
    step();
    snd_cmd = 1'b0;
    repeat (5 * BD + BD / 2) step();
    chk("mid_tx_low", {31'd0, TX}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", {31'd0, TX}, 32'd1);
    chk("mid_rst_snt", {31'd0, cmd_snt}, 32'd0);
    chk("mid_rst_rdy", {31'd0, resp_rdy}, 32'd0);
    chk("mid_rst_resp", {24'd0, resp}, 32'h00);
    repeat (3) step();
    chk("mid_rst_tx_hold", {31'd0, TX}, 32'd1);
    rst_n = 1'b1;
    step();
    run_cmd(16'hC33C, 1'b0);
  endtask

  initial begin
    test_reset();
    test_cmd_basic();
    test_cmd_latch();
    test_rx();
    test_back_to_back();
    test_simultaneous();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
